mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Round-robin arbiter sharing one memory port (req/addr/we/wdata/wstrb -> rdata/rdata_valid)
//  between NUM_REQ requesters, e.g. the APB slave wrapper and a DMA/debug master.
//  Issues one access at a time. Tracks the single outstanding read and routes returned data
//  and completion back to the owning requester.
// PARAMETERS
//  NUM_REQ      2   number of requesters (>=2)
//  ADDR_W       32  address width
//  DATA_W       64  data width; strobe width DATA_W/8
//  TIMEOUT_CYC  16  read-timeout limit in cycles (used only with MEM_ARB_TIMEOUT_EN)
// PORTS
//  PCLK         in   1                clock, all logic on rising edge
//  PRESET       in   1                asynchronous, active-high reset
//  req_i        in   NUM_REQ          per-requester request, held high until ack_o
//  we_i         in   NUM_REQ          per-requester write enable
//  addr_i       in   NUM_REQ*ADDR_W   packed addresses, requester k at [k*ADDR_W +: ADDR_W]
//  wdata_i      in   NUM_REQ*DATA_W   packed write data
//  wstrb_i      in   NUM_REQ*DATA_W/8 packed byte strobes
//  gnt_o        out  NUM_REQ          one-hot current owner, ISSUE..RESP inclusive
//  ack_o        out  NUM_REQ          one-cycle completion pulse to owner
//  err_o        out  NUM_REQ          error qualifier, valid with ack_o
//  rdata_o      out  DATA_W           read data, valid with ack_o of a read
//  busy_o       out  1                high whenever state != IDLE
//  mem_req_o    out  1                one-cycle memory request
//  mem_we_o / mem_addr_o / mem_wdata_o / mem_wstrb_o  out  1/ADDR_W/DATA_W/DATA_W/8
//                                     registered, stable while mem_req_o is high
//  mem_rdata_i  in   DATA_W           memory read data
//  mem_rdata_valid_i in 1             memory read data valid
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0; rr pointer = 0 (requester 0 highest priority).
//  - FSM IDLE -> ISSUE -> (write) IDLE | (read) RD_WAIT -> RESP -> IDLE.
//  - IDLE: if any req_i, pick the first set bit scanning from the rr pointer upward (mod NUM_REQ).
//    Register the winner's we/addr/wdata/wstrb onto mem_*_o. Set gnt_o. Go to ISSUE.
//    The rr pointer becomes winner+1 mod NUM_REQ.
//  - ISSUE (1 cycle): mem_req_o=1.
//    - Write: ack_o[winner]=1 in this same cycle; next IDLE.
//    - Read: next RD_WAIT. mem_rdata_valid_i is also sampled in ISSUE (zero-wait memory).
//  - RD_WAIT: on mem_rdata_valid_i, capture mem_rdata_i into rdata_o and go to RESP.
//  - RESP (1 cycle): ack_o[winner]=1, err_o=0. rdata_o holds until the next read capture.
//  - Latency: req_i at cycle N -> mem_req_o at N+1.
//    - Write ack at N+1.
//    - Read ack one cycle after valid.
//    - Minimum cycles per transaction: write 2, read 3.
//  - Requester drops req_i the cycle after ack_o. The arbiter never samples req_i in the ack cycle,
//    so double issue is impossible.
//  - req_i dropped early by owner: the transaction still completes and ack is still pulsed.
//    Its inputs are not re-sampled (registered at grant).
//  - mem_rdata_valid_i outside ISSUE-read/RD_WAIT is ignored.
//  - A new request arriving during a transaction waits. Arbitration happens only in IDLE.
//  - Reset mid-transaction: immediate return to IDLE, outputs 0, outstanding read abandoned.
//    A late valid is ignored.
//  - All requesters continuously requesting are served in strict rotation 0,1,..,NUM_REQ-1,0.
// CONFIGURATION
//  MEM_ARB_TIMEOUT_EN defined:
//    - A counter clears on entry to RD_WAIT and increments each RD_WAIT cycle.
//    - When it reaches TIMEOUT_CYC without valid, go to RESP with ack_o=1, err_o[winner]=1,
//      rdata_o=0.
//    - A valid arriving in that same cycle wins (normal data, no error).
//  Not defined: RD_WAIT waits indefinitely; err_o tied to 0; no counter logic.
// TESTING
//  1. Reset: PRESET=1 mid-read -> all outputs 0 next cycle; after release a late valid
//     produces no ack.
//  2. Single write: req0 we=1 addr=0x40 wdata=0xDEAD strb=0xFF ->
//     mem_req_o, mem_addr_o=0x40 and ack_o=01 in cycle N+1; busy_o low at N+2.
//  3. Single read: req1 addr=0x80, memory returns 0x1234 after 3 cycles ->
//     ack_o=10 with rdata_o=0x1234, one cycle after valid.
//  4. Contention: req0 and req1 held continuously for 4 transactions ->
//     grant order 0,1,0,1; then pointer at 0 and only req1 -> 1 granted.
//  5. Timeout (MEM_ARB_TIMEOUT_EN, TIMEOUT_CYC=16): read with no valid ->
//     ack+err on the owner 16 RD_WAIT cycles later, rdata_o=0; valid at cycle 16 -> no error.
//  6. Early drop: req0 deasserted in ISSUE of a read -> read still completes and ack_o[0] pulses.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester and memory-side signals of the shared memory port.
// slave is the arbiter's view; master is the environment (requesters plus memory).
interface mem_port_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 64
);
    logic [NUM_REQ-1:0]          req_i;
    logic [NUM_REQ-1:0]          we_i;
    logic [NUM_REQ*ADDR_W-1:0]   addr_i;
    logic [NUM_REQ*DATA_W-1:0]   wdata_i;
    logic [NUM_REQ*DATA_W/8-1:0] wstrb_i;
    logic [NUM_REQ-1:0]          gnt_o;
    logic [NUM_REQ-1:0]          ack_o;
    logic [NUM_REQ-1:0]          err_o;
    logic [DATA_W-1:0]           rdata_o;
    logic                        busy_o;
    logic                        mem_req_o;
    logic                        mem_we_o;
    logic [ADDR_W-1:0]           mem_addr_o;
    logic [DATA_W-1:0]           mem_wdata_o;
    logic [DATA_W/8-1:0]         mem_wstrb_o;
    logic [DATA_W-1:0]           mem_rdata_i;
    logic                        mem_rdata_valid_i;
    modport slave (
        input  req_i, we_i, addr_i, wdata_i, wstrb_i, mem_rdata_i, mem_rdata_valid_i,
        output gnt_o, ack_o, err_o, rdata_o, busy_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o
    );
    modport master (
        output req_i, we_i, addr_i, wdata_i, wstrb_i, mem_rdata_i, mem_rdata_valid_i,
        input  gnt_o, ack_o, err_o, rdata_o, busy_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of one memory port, one access at a time.
// Define MEM_ARB_TIMEOUT_EN to abandon reads after TIMEOUT_CYC wait cycles with err_o.
module mem_port_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 64
`ifdef MEM_ARB_TIMEOUT_EN
    , parameter int TIMEOUT_CYC = 16
`endif
) (
    input logic               PCLK,
    input logic               PRESET,
    mem_port_arbiter_if.slave bus
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int SW = DATA_W / 8;
    typedef enum logic [1:0] {IDLE, ISSUE, RD_WAIT, RESP} state_t;
    state_t            state, state_n;
    logic [IW-1:0]     rr_ptr, owner, win, idx;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, rdata_q;
    logic [SW-1:0]     wstrb_q;
    logic [NUM_REQ-1:0] own_oh;
    logic              rd_valid, timeout;
    // Scan downward so the requester closest above the pointer is the last one kept.
    always_comb begin
        win = rr_ptr;
        idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = IW'((int'(rr_ptr) + i) % NUM_REQ);
            if (bus.req_i[idx]) win = idx;
        end
    end
    assign own_oh   = NUM_REQ'(1) << owner;
    assign rd_valid = bus.mem_rdata_valid_i && ((state == ISSUE && !we_q) || state == RD_WAIT);
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = |bus.req_i ? ISSUE : IDLE;
            ISSUE:   state_n = we_q ? IDLE : (rd_valid ? RESP : RD_WAIT);
            RD_WAIT: state_n = (rd_valid || timeout) ? RESP : RD_WAIT;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state   <= IDLE;
            rr_ptr  <= '0;
            owner   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rdata_q <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && |bus.req_i) begin
                owner   <= win;
                rr_ptr  <= (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
                we_q    <= bus.we_i[win];
                addr_q  <= bus.addr_i[int'(win)*ADDR_W +: ADDR_W];
                wdata_q <= bus.wdata_i[int'(win)*DATA_W +: DATA_W];
                wstrb_q <= bus.wstrb_i[int'(win)*SW +: SW];
            end
            if (rd_valid) rdata_q <= bus.mem_rdata_i;
            else if (timeout) rdata_q <= '0;
        end
    end
`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] cnt;
    logic          err_q;
    // cnt holds the number of RD_WAIT cycles already completed; a same-cycle valid beats the timeout.
    assign timeout = state == RD_WAIT && !bus.mem_rdata_valid_i && cnt == CW'(TIMEOUT_CYC - 1);
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            cnt   <= '0;
            err_q <= 1'b0;
        end else begin
            cnt   <= (state == RD_WAIT) ? cnt + 1'b1 : '0;
            err_q <= timeout;
        end
    end
    assign bus.err_o = (state == RESP && err_q) ? own_oh : '0;
`else
    assign timeout   = 1'b0;
    assign bus.err_o = '0;
`endif
    assign bus.busy_o      = state != IDLE;
    assign bus.gnt_o       = (state != IDLE) ? own_oh : '0;
    assign bus.ack_o       = ((state == ISSUE && we_q) || state == RESP) ? own_oh : '0;
    assign bus.mem_req_o   = state == ISSUE;
    assign bus.mem_we_o    = we_q;
    assign bus.mem_addr_o  = addr_q;
    assign bus.mem_wdata_o = wdata_q;
    assign bus.mem_wstrb_o = wstrb_q;
    assign bus.rdata_o     = rdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed transactions checked each cycle against a transaction-level model,
// plus hand-computed literal expectations. Timeout cases build only with MEM_ARB_TIMEOUT_EN.
module tb_mem_port_arbiter;
    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 64;
    localparam int SW = DW / 8;
    localparam int TO = 16;
    logic PCLK = 1'b0;
    logic PRESET = 1'b1;
    int passed = 0;
    int total = 0;
    int cyc = 0;
    bit chk_en = 1'b0;
    always #5 PCLK = ~PCLK;
    mem_port_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();
    mem_port_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (.PCLK(PCLK), .PRESET(PRESET), .bus(bus));
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    endtask
    // Model: one transaction record; cycles are numbered, issue is grant+1,
    // a write acks at issue, a read acks the cycle after its data arrives.
    bit m_act = 0;
    bit m_wr = 0;
    bit m_err = 0;
    int m_own = 0;
    int m_ptr = 0;
    int m_issue = -1;
    int m_ack = -1;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0;
    logic [DW-1:0] m_rdata = '0;
    logic [SW-1:0] m_wstrb = '0;
    always @(posedge PCLK) cyc <= cyc + 1;
    always @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            m_act = 0; m_wr = 0; m_err = 0; m_own = 0; m_ptr = 0;
            m_issue = -1; m_ack = -1;
            m_addr = '0; m_wdata = '0; m_rdata = '0; m_wstrb = '0;
        end else if (!m_act) begin
            if (|bus.req_i) begin
                for (int k = 0; k < N; k++)
                    if (bus.req_i[(m_ptr + k) % N]) begin
                        m_own = (m_ptr + k) % N;
                        break;
                    end
                m_act = 1;
                m_ptr = (m_own + 1) % N;
                m_wr = bus.we_i[m_own];
                m_addr = bus.addr_i[m_own*AW +: AW];
                m_wdata = bus.wdata_i[m_own*DW +: DW];
                m_wstrb = bus.wstrb_i[m_own*SW +: SW];
                m_issue = cyc + 1;
                m_ack = m_wr ? cyc + 1 : -1;
                m_err = 0;
            end
        end else if (cyc == m_ack) begin
            m_act = 0;
        end else if (m_ack < 0 && cyc >= m_issue) begin
            if (bus.mem_rdata_valid_i) begin
                m_rdata = bus.mem_rdata_i;
                m_ack = cyc + 1;
            end
`ifdef MEM_ARB_TIMEOUT_EN
            else if (cyc - m_issue == TO) begin
                m_rdata = '0;
                m_err = 1;
                m_ack = cyc + 1;
            end
`endif
        end
    end
    always @(negedge PCLK) begin
        if (chk_en) begin
            chk("busy", 64'(bus.busy_o), 64'(m_act));
            chk("gnt", 64'(bus.gnt_o), m_act ? 64'(1) << m_own : 64'(0));
            chk("ack", 64'(bus.ack_o), (m_act && cyc == m_ack) ? 64'(1) << m_own : 64'(0));
            chk("err", 64'(bus.err_o), (m_act && cyc == m_ack && m_err) ? 64'(1) << m_own : 64'(0));
            chk("mem_req", 64'(bus.mem_req_o), 64'(m_act && cyc == m_issue));
            chk("mem_we", 64'(bus.mem_we_o), 64'(m_wr));
            chk("mem_addr", 64'(bus.mem_addr_o), 64'(m_addr));
            chk("mem_wdata", bus.mem_wdata_o, m_wdata);
            chk("mem_wstrb", 64'(bus.mem_wstrb_o), 64'(m_wstrb));
            chk("rdata", bus.rdata_o, m_rdata);
        end
    end
    task automatic tick;
        @(posedge PCLK);
        #1;
    endtask
    task automatic obs;
        @(negedge PCLK);
    endtask
    task automatic set_req(input int k, input bit r, input bit w, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [SW-1:0] s);
        bus.req_i[k] = r;
        bus.we_i[k] = w;
        bus.addr_i[k*AW +: AW] = a;
        bus.wdata_i[k*DW +: DW] = d;
        bus.wstrb_i[k*SW +: SW] = s;
    endtask
    task automatic mem_drive(input bit v, input logic [DW-1:0] d);
        bus.mem_rdata_valid_i = v;
        bus.mem_rdata_i = d;
    endtask
    // Counts negedges from the current cycle up to and including the ack cycle.
    task automatic wait_ack(input int lim, output int n);
        n = 0;
        do begin
            @(negedge PCLK);
            n++;
        end while (bus.ack_o == '0 && n < lim);
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
    initial begin
        int n;
        bus.req_i = '0; bus.we_i = '0; bus.addr_i = '0; bus.wdata_i = '0; bus.wstrb_i = '0;
        mem_drive(0, '0);
        repeat (2) @(posedge PCLK);
        #1 PRESET = 1'b0;
        chk_en = 1'b1;
        obs;
        chk("reset_busy", 64'(bus.busy_o), 0);
        chk("reset_gnt", 64'(bus.gnt_o), 0);
        chk("reset_rdata", bus.rdata_o, 0);
        // single write on requester 0
        tick; set_req(0, 1, 1, 32'h40, 64'hDEAD, 8'hFF);
        obs; chk("wr_idle", 64'(bus.mem_req_o), 0);
        tick; obs;
        chk("wr_mem_req", 64'(bus.mem_req_o), 1);
        chk("wr_addr", 64'(bus.mem_addr_o), 64'h40);
        chk("wr_ack", 64'(bus.ack_o), 64'b01);
        tick; set_req(0, 0, 0, '0, '0, '0);
        obs;
        chk("wr_busy_n2", 64'(bus.busy_o), 0);
        // read on requester 1, data three cycles after the request
        tick; set_req(1, 1, 0, 32'h80, '0, '0);
        tick; obs;
        chk("rd_mem_req", 64'(bus.mem_req_o), 1);
        chk("rd_addr", 64'(bus.mem_addr_o), 64'h80);
        chk("rd_gnt", 64'(bus.gnt_o), 64'b10);
        tick; tick; tick; mem_drive(1, 64'h1234);
        obs; chk("rd_no_ack_on_valid", 64'(bus.ack_o), 0);
        tick; mem_drive(0, '0);
        obs;
        chk("rd_ack", 64'(bus.ack_o), 64'b10);
        chk("rd_data", bus.rdata_o, 64'h1234);
        tick; set_req(1, 0, 0, '0, '0, '0);
        obs; chk("rd_hold", bus.rdata_o, 64'h1234);
        // zero-wait read on requester 1: valid during the issue cycle
        tick; set_req(1, 1, 0, 32'hC0, '0, '0);
        tick; mem_drive(1, 64'h55AA);
        obs; chk("zw_mem_req", 64'(bus.mem_req_o), 1);
        tick; mem_drive(0, '0);
        obs;
        chk("zw_ack", 64'(bus.ack_o), 64'b10);
        chk("zw_data", bus.rdata_o, 64'h55AA);
        tick; set_req(1, 0, 0, '0, '0, '0);
        // stray valid while idle is ignored
        tick; mem_drive(1, 64'hFFFF);
        tick; mem_drive(0, '0);
        obs;
        chk("stray_rdata", bus.rdata_o, 64'h55AA);
        chk("stray_ack", 64'(bus.ack_o), 0);
        // contention: both requesters write continuously, strict rotation from pointer 0
        tick;
        set_req(0, 1, 1, 32'h200, 64'hA0, 8'h0F);
        set_req(1, 1, 1, 32'h300, 64'hB1, 8'hF0);
        for (int t = 0; t < 4; t++) begin
            wait_ack(8, n);
            chk("rot_ack", 64'(bus.ack_o), (t % 2 == 1) ? 64'b10 : 64'b01);
            chk("rot_addr", 64'(bus.mem_addr_o), (t % 2 == 1) ? 64'h300 : 64'h200);
        end
        tick; set_req(0, 0, 0, '0, '0, '0);
        wait_ack(8, n);
        chk("rot_only1", 64'(bus.ack_o), 64'b10);
        tick; set_req(1, 0, 0, '0, '0, '0);
        // early drop: requester 0 releases req during issue of its read
        tick; set_req(0, 1, 0, 32'h100, '0, '0);
        tick; set_req(0, 0, 0, 32'h100, '0, '0);
        obs;
        chk("drop_mem_req", 64'(bus.mem_req_o), 1);
        chk("drop_gnt", 64'(bus.gnt_o), 64'b01);
        tick; mem_drive(1, 64'hABCD);
        tick; mem_drive(0, '0);
        obs;
        chk("drop_ack", 64'(bus.ack_o), 64'b01);
        chk("drop_data", bus.rdata_o, 64'hABCD);
        // reset in the middle of a read, then a late valid
        tick; set_req(1, 1, 0, 32'h180, '0, '0);
        tick; tick; PRESET = 1'b1;
        obs;
        chk("rst_busy", 64'(bus.busy_o), 0);
        chk("rst_gnt", 64'(bus.gnt_o), 0);
        chk("rst_addr", 64'(bus.mem_addr_o), 0);
        chk("rst_rdata", bus.rdata_o, 0);
        tick; PRESET = 1'b0; set_req(1, 0, 0, '0, '0, '0);
        tick; mem_drive(1, 64'h7777);
        obs; chk("late_ack", 64'(bus.ack_o), 0);
        tick; mem_drive(0, '0);
        obs;
        chk("late_rdata", bus.rdata_o, 0);
        chk("late_busy", 64'(bus.busy_o), 0);
`ifdef MEM_ARB_TIMEOUT_EN
        // read that never completes: ack+err 16 wait cycles after issue
        tick; set_req(0, 1, 0, 32'h40, '0, '0);
        wait_ack(40, n);
        chk("to_latency", 64'(n), 19);
        chk("to_err", 64'(bus.err_o), 64'b01);
        chk("to_rdata", bus.rdata_o, 0);
        tick; set_req(0, 0, 0, '0, '0, '0);
        // valid on the last wait cycle wins over the timeout
        tick; set_req(1, 1, 0, 32'h48, '0, '0);
        repeat (17) tick;
        mem_drive(1, 64'h99);
        tick; mem_drive(0, '0);
        obs;
        chk("to_edge_ack", 64'(bus.ack_o), 64'b10);
        chk("to_edge_err", 64'(bus.err_o), 0);
        chk("to_edge_data", bus.rdata_o, 64'h99);
        tick; set_req(1, 0, 0, '0, '0, '0);
`endif
        repeat (3) tick;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
